// File: rtl/lsu_ctrl_if.sv
// Bundle between execute stage, data-memory bus and the lsu_ctrl controller.
// Latency: none, wires only.
// Backpressure: req_ready/busy stall the requester; the response side has no stall.
interface lsu_ctrl_if;
  // execute-stage request
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // data-memory bus
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;
  // completion towards load-data extraction
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [3:0]  resp_be;
  logic [2:0]  resp_f3;
  logic        resp_we;
  logic [1:0]  resp_cause;
  logic        busy;

  // Environment view: execute stage plus memory responder.
  modport master (
    output req_valid, req_we, req_f3, req_addr, req_wdata,
    output mem_ack, mem_rdata, mem_err,
    input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  resp_valid, resp_data, resp_be, resp_f3, resp_we, resp_cause, busy
  );

  // Controller view.
  modport slave (
    input  req_valid, req_we, req_f3, req_addr, req_wdata,
    input  mem_ack, mem_rdata, mem_err,
    output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output resp_valid, resp_data, resp_be, resp_f3, resp_we, resp_cause, busy
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: alignment check, byte enables, lane replication, bus handshake with timeout.
// Latency: 2 cycles minimum (accept -> resp_valid), 1 cycle for faulted accesses.
// Backpressure: one access in flight, busy stalls the pipe; the response cannot be stalled.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic       clk,
  input logic       rst,
  lsu_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUS, RESP, FAULT} state_t;

  // Last wait count before the abort; mem_req is then held exactly TIMEOUT_CYCLES cycles.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] wait_cnt;
  logic        cap_we;
  logic [2:0]  cap_f3;

  logic        mem_req_r;
  logic        mem_we_r;
  logic [31:0] mem_addr_r;
  logic [3:0]  mem_be_r;
  logic [31:0] mem_wdata_r;

  logic        resp_valid_r;
  logic [31:0] resp_data_r;
  logic [3:0]  resp_be_r;
  logic [2:0]  resp_f3_r;
  logic        resp_we_r;
  logic [1:0]  resp_cause_r;

  logic        ready;
  logic        accept;
  logic        f3_ok;
  logic        aligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  assign ready  = (state == IDLE) && !rst;
  assign accept = bus.req_valid && ready;

  // Decode of the presented request: legality, alignment, lane mask and replicated data.
  always_comb begin
    f3_ok      = 1'b0;
    aligned    = 1'b0;
    be_calc    = 4'b1111;
    wdata_calc = bus.req_wdata;
    if (bus.req_we) begin
      f3_ok = (bus.req_f3 == 3'b000) || (bus.req_f3 == 3'b001) || (bus.req_f3 == 3'b010);
    end else begin
      f3_ok = (bus.req_f3 == 3'b000) || (bus.req_f3 == 3'b001) || (bus.req_f3 == 3'b010) ||
              (bus.req_f3 == 3'b100) || (bus.req_f3 == 3'b101);
    end
    case (bus.req_f3[1:0])
      2'b00: begin
        aligned    = 1'b1;
        be_calc    = 4'b0001 << bus.req_addr[1:0];
        wdata_calc = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        aligned    = !bus.req_addr[0];
        be_calc    = 4'b0011 << bus.req_addr[1:0];
        wdata_calc = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        aligned    = (bus.req_addr[1:0] == 2'b00);
        be_calc    = 4'b1111;
        wdata_calc = bus.req_wdata;
      end
      default: begin
        aligned    = 1'b0;
        be_calc    = 4'b0000;
        wdata_calc = bus.req_wdata;
      end
    endcase
  end

  // Sequencer: accept, run the bus handshake or fault immediately, then emit one response pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      cap_we       <= 1'b0;
      cap_f3       <= 3'b000;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_be_r     <= '0;
      mem_wdata_r  <= '0;
      resp_valid_r <= 1'b0;
      resp_data_r  <= '0;
      resp_be_r    <= '0;
      resp_f3_r    <= 3'b000;
      resp_we_r    <= 1'b0;
      resp_cause_r <= 2'b00;
    end else begin
      resp_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cap_we   <= bus.req_we;
            cap_f3   <= bus.req_f3;
            wait_cnt <= '0;
            if (!(f3_ok && aligned)) begin
              // Faulted access never touches the bus.
              state        <= FAULT;
              resp_valid_r <= 1'b1;
              resp_data_r  <= '0;
              resp_be_r    <= 4'b0000;
              resp_f3_r    <= bus.req_f3;
              resp_we_r    <= bus.req_we;
              resp_cause_r <= 2'b01;
            end else begin
              state       <= BUS;
              mem_req_r   <= 1'b1;
              mem_we_r    <= bus.req_we;
              mem_addr_r  <= {bus.req_addr[31:2], 2'b00};
              mem_be_r    <= be_calc;
              mem_wdata_r <= wdata_calc;
            end
          end
        end
        BUS: begin
          // Error beats ack, ack beats timeout.
          if (bus.mem_err || bus.mem_ack || (wait_cnt == TMO_LAST)) begin
            state        <= RESP;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            resp_valid_r <= 1'b1;
            resp_be_r    <= mem_be_r;
            resp_f3_r    <= cap_f3;
            resp_we_r    <= cap_we;
            if (bus.mem_err) begin
              resp_cause_r <= 2'b10;
              resp_data_r  <= '0;
            end else if (bus.mem_ack) begin
              resp_cause_r <= 2'b00;
              resp_data_r  <= cap_we ? 32'h0 : bus.mem_rdata;
            end else begin
              resp_cause_r <= 2'b11;
              resp_data_r  <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP, FAULT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready;
  assign bus.busy       = (state != IDLE) || accept;
  assign bus.mem_req    = mem_req_r;
  assign bus.mem_we     = mem_we_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_be     = mem_be_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_data  = resp_data_r;
  assign bus.resp_be    = resp_be_r;
  assign bus.resp_f3    = resp_f3_r;
  assign bus.resp_we    = resp_we_r;
  assign bus.resp_cause = resp_cause_r;

endmodule
